// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared opcode constants and issuer state encoding
// Contents: 4-bit opcode constants CMD_WRITE..CMD_MIRROR_Y, CMD_LAST,
//           issuer state width STATE_W and state enum issuer_state_e.
package lcd_pkg;

   localparam int STATE_W = 2;

   localparam logic [3:0] CMD_WRITE       = 4'd0;
   localparam logic [3:0] CMD_SHIFT_UP    = 4'd1;
   localparam logic [3:0] CMD_SHIFT_DOWN  = 4'd2;
   localparam logic [3:0] CMD_SHIFT_LEFT  = 4'd3;
   localparam logic [3:0] CMD_SHIFT_RIGHT = 4'd4;
   localparam logic [3:0] CMD_MAX         = 4'd5;
   localparam logic [3:0] CMD_MIN         = 4'd6;
   localparam logic [3:0] CMD_AVERAGE     = 4'd7;
   localparam logic [3:0] CMD_ROT_CCW     = 4'd8;
   localparam logic [3:0] CMD_ROT_CW      = 4'd9;
   localparam logic [3:0] CMD_MIRROR_X    = 4'd10;
   localparam logic [3:0] CMD_MIRROR_Y    = 4'd11;
   localparam logic [3:0] CMD_LAST        = CMD_MIRROR_Y;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT_HI = 2'd2,
      ST_WAIT_LO = 2'd3
   } issuer_state_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// rtl/lcd_cmd_fifo.sv - synchronous opcode FIFO
// Ports: clk, reset (async, active-high), push/din write side,
//        pop/head read side (head is the oldest entry), full, empty.
module lcd_cmd_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [3:0] din,
   input  logic       pop,
   output logic [3:0] head,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [3:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // storage needs no reset: entries are only read once count says they are valid
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + (AW+1)'(1);
         end else if (do_pop && !do_push) begin
            count <= count - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/lcd_cmd_issuer.sv
// rtl/lcd_cmd_issuer.sv - host opcode buffer and one-at-a-time command issuer
// Ports: clk, reset (async, active-high); host_cmd/host_valid/host_ready host
//        stream; cmd/cmd_valid issue strobe and busy/done from the controller;
//        frame_done pulse, issued_cnt, idle status.
// Option LCD_CMD_CHECK_EN: opcodes above CMD_LAST are dropped and flagged on bad_cmd.
module lcd_cmd_issuer
   import lcd_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       host_cmd,
   input  logic             host_valid,
   output logic             host_ready,
   output logic [3:0]       cmd,
   output logic             cmd_valid,
   input  logic             busy,
   input  logic             done,
   output logic             frame_done,
   output logic [CNT_W-1:0] issued_cnt,
   output logic             idle
`ifdef LCD_CMD_CHECK_EN
   ,
   output logic             bad_cmd
`endif
);

   localparam logic [STATE_W-1:0] IDLE    = ST_IDLE;
   localparam logic [STATE_W-1:0] ISSUE   = ST_ISSUE;
   localparam logic [STATE_W-1:0] WAIT_HI = ST_WAIT_HI;
   localparam logic [STATE_W-1:0] WAIT_LO = ST_WAIT_LO;

   logic [STATE_W-1:0] state;
   logic [3:0]         head;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic               done_d;
   logic               head_bad;

   // full blocks the host even when a pop lands on the same edge
   assign host_ready = !full;
   assign push       = host_valid && host_ready;
   assign pop        = (state == IDLE) && !busy && !empty;
   assign idle       = empty && (state == IDLE) && !busy;

`ifdef LCD_CMD_CHECK_EN
   assign head_bad = (head > CMD_LAST);
`else
   assign head_bad = 1'b0;
`endif

   lcd_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (host_cmd),
      .pop   (pop),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cmd        <= '0;
         cmd_valid  <= 1'b0;
         issued_cnt <= '0;
`ifdef LCD_CMD_CHECK_EN
         bad_cmd    <= 1'b0;
`endif
      end else begin
         cmd_valid <= 1'b0;
`ifdef LCD_CMD_CHECK_EN
         bad_cmd   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (pop) begin
                  if (head_bad) begin
`ifdef LCD_CMD_CHECK_EN
                     bad_cmd <= 1'b1;
`endif
                  end else begin
                     cmd        <= head;
                     cmd_valid  <= 1'b1;
                     issued_cnt <= issued_cnt + CNT_W'(1);
                     state      <= ISSUE;
                  end
               end
            end
            ISSUE:   state <= WAIT_HI;
            // controller raises busy the edge after it samples the strobe
            WAIT_HI: if (busy)  state <= WAIT_LO;
            WAIT_LO: if (!busy) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_d     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         done_d     <= done;
         frame_done <= done && !done_d;
      end
   end

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// tb/tb_lcd_cmd_issuer.sv - scoreboard bench for lcd_cmd_issuer
module tb_lcd_cmd_issuer;

   localparam int DEPTH = 8;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       host_cmd;
   logic             host_valid;
   logic             host_ready;
   logic [3:0]       cmd;
   logic             cmd_valid;
   logic             busy;
   logic             done;
   logic             frame_done;
   logic [CNT_W-1:0] issued_cnt;
   logic             idle;
`ifdef LCD_CMD_CHECK_EN
   logic             bad_cmd;
`endif

   lcd_cmd_issuer #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .host_cmd   (host_cmd),
      .host_valid (host_valid),
      .host_ready (host_ready),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .busy       (busy),
      .done       (done),
      .frame_done (frame_done),
      .issued_cnt (issued_cnt),
      .idle       (idle)
`ifdef LCD_CMD_CHECK_EN
      ,
      .bad_cmd    (bad_cmd)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [3:0] sb [$];
   int exp_issued = 0;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // controller model: busy rises the cycle after the strobe, holds busy_len cycles
   logic busy_force = 1'b1;
   logic model_busy = 1'b0;
   int   busy_len   = 1;
   int   m_state    = 0;
   int   m_rem      = 0;
   assign busy = busy_force | model_busy;

   always @(negedge clk) begin
      if (reset) begin
         m_state    = 0;
         model_busy = 1'b0;
      end else if (m_state == 0) begin
         if (cmd_valid) m_state = 1;
      end else if (m_state == 1) begin
         model_busy = 1'b1;
         m_rem      = busy_len;
         m_state    = 2;
      end else begin
         m_rem = m_rem - 1;
         if (m_rem <= 0) begin
            model_busy = 1'b0;
            m_state    = 0;
         end
      end
   end

   // output monitor
   int   strobe_cnt = 0;
   int   fd_cnt     = 0;
   int   bad_cnt    = 0;
   int   last_cyc   = -1;
   logic prev_cv    = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         strobe_cnt = 0;
         fd_cnt     = 0;
         bad_cnt    = 0;
         last_cyc   = -1;
         prev_cv    = 1'b0;
      end else begin
         if (cmd_valid) begin
            strobe_cnt++;
            check_eq("strobe_while_busy", busy, 0);
            check_eq("strobe_width", prev_cv, 0);
            if (last_cyc >= 0) check_eq("strobe_spacing_ge4", (cyc - last_cyc) >= 4, 1);
            last_cyc = cyc;
            if (sb.size() == 0) check_eq("unexpected_strobe", 1, 0);
            else check_eq("cmd_order", cmd, sb.pop_front());
         end
         prev_cv = cmd_valid;
         if (frame_done) fd_cnt++;
`ifdef LCD_CMD_CHECK_EN
         if (bad_cmd) bad_cnt++;
`endif
      end
   end

   // called at a negedge; returns at a negedge after the accepting posedge
   task automatic push_op(input logic [3:0] op, input bit valid_op);
      int n = 0;
      host_cmd   = op;
      host_valid = 1'b1;
      while (!host_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!host_ready) begin
         check_eq("push_timeout", 0, 1);
      end else if (valid_op) begin
         sb.push_back(op);
         exp_issued++;
      end
      @(negedge clk);
      host_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (!(idle && sb.size() == 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, idle && sb.size() == 0, 1);
   endtask

   int base;

   initial begin
      reset      = 1'b1;
      host_cmd   = '0;
      host_valid = 1'b0;
      done       = 1'b0;
      repeat (3) @(negedge clk);

      check_eq("rst_cmd", cmd, 0);
      check_eq("rst_cmd_valid", cmd_valid, 0);
      check_eq("rst_frame_done", frame_done, 0);
      check_eq("rst_issued_cnt", issued_cnt, 0);
      check_eq("rst_host_ready", host_ready, 1);
      reset = 1'b0;

      // 1: nothing issues while busy is held high during image load
      repeat (70) @(negedge clk);
      check_eq("t1_ready_a", host_ready, 1);
      push_op(4'd3, 1'b1);
      check_eq("t1_ready_b", host_ready, 1);
      push_op(4'd5, 1'b1);
      check_eq("t1_ready_c", host_ready, 1);
      push_op(4'd1, 1'b1);
      repeat (10) @(negedge clk);
      check_eq("t1_no_strobe_busy", strobe_cnt, 0);
      check_eq("t1_not_idle_busy", idle, 0);
      busy_force = 1'b0;
      wait_idle("t1_drain");
      check_eq("t1_issued_cnt", issued_cnt, 3);
      check_eq("t1_strobes", strobe_cnt, exp_issued);

      // 2: FIFO fills, ninth opcode waits for the first pop
      busy_force = 1'b1;
      @(negedge clk);
      for (int i = 0; i < DEPTH; i++) push_op(4'(i + 2), 1'b1);
      check_eq("t2_full_not_ready", host_ready, 0);
      fork
         push_op(4'd11, 1'b1);
         begin
            int n = 0;
            repeat (5) @(negedge clk);
            check_eq("t2_still_full", host_ready, 0);
            busy_force = 1'b0;
            while (!cmd_valid && n < 50) begin
               @(negedge clk);
               n++;
            end
            check_eq("t2_first_issue", cmd_valid, 1);
            check_eq("t2_ready_after_pop", host_ready, 1);
         end
      join
      wait_idle("t2_drain");
      check_eq("t2_issued_cnt", issued_cnt, CNT_W'(exp_issued));

      // 3: back-to-back issues through the controller model
      push_op(4'd4, 1'b1);
      push_op(4'd9, 1'b1);
      push_op(4'd10, 1'b1);
      push_op(4'd1, 1'b1);
      wait_idle("t3_drain");
      check_eq("t3_issued_cnt", issued_cnt, CNT_W'(exp_issued));
      check_eq("t3_strobes", strobe_cnt, exp_issued);

      // 4: long write, done pulse, queued opcode waits for busy to fall
      busy_len = 66;
      push_op(4'd0, 1'b1);
      repeat (10) @(negedge clk);
      check_eq("t4_write_busy", busy, 1);
      base = strobe_cnt;
      push_op(4'd2, 1'b1);
      repeat (20) @(negedge clk);
      check_eq("t4_no_issue_during_busy", strobe_cnt, base);
      done = 1'b1;
      check_eq("t4_fd_before", frame_done, 0);
      @(negedge clk);
      check_eq("t4_fd_pulse", frame_done, 1);
      @(negedge clk);
      check_eq("t4_fd_one_cycle", frame_done, 0);
      repeat (3) @(negedge clk);
      done = 1'b0;
      wait_idle("t4_drain");
      check_eq("t4_issued_cnt", issued_cnt, CNT_W'(exp_issued));
      check_eq("t4_fd_count", fd_cnt, 1);

      // 5: reset in WAIT_LO with entries queued
      push_op(4'd6, 1'b1);
      for (int i = 0; i < 5; i++) push_op(4'(i + 1), 1'b1);
      check_eq("t5_in_wait_lo_busy", busy, 1);
      reset = 1'b1;
      #1;
      check_eq("t5_rst_cmd_valid", cmd_valid, 0);
      check_eq("t5_rst_issued_cnt", issued_cnt, 0);
      check_eq("t5_rst_host_ready", host_ready, 1);
      check_eq("t5_rst_cmd", cmd, 0);
      sb.delete();
      exp_issued = 0;
      busy_len   = 1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check_eq("t5_no_strobe_after", strobe_cnt, 0);
      check_eq("t5_issued_cnt", issued_cnt, 0);
      check_eq("t5_idle", idle, 1);

`ifdef LCD_CMD_CHECK_EN
      // 6: out-of-range opcode dropped and flagged
      push_op(4'd14, 1'b0);
      push_op(4'd7, 1'b1);
      wait_idle("t6_drain");
      check_eq("t6_bad_cnt", bad_cnt, 1);
      check_eq("t6_strobes", strobe_cnt, 1);
      check_eq("t6_issued_cnt", issued_cnt, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
